// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the PC register and picks the next PC each cycle from, in priority
// order: reset, trap vector, misaligned-redirect trap, redirect target, stall
// (hold), return-address-stack pop, and sequential pc + INC.
//
// Ports:
//   i_clk              clock, all state updates on the rising edge
//   i_rst              synchronous active-high reset
//   i_stall            hold PC (overridden by trap / redirect)
//   i_redirect_valid   load i_redirect_target as next PC
//   i_redirect_target  branch/jump destination
//   i_call             push pc + INC onto the RAS (only with redirect)
//   i_ret              pop the RAS top as next PC
//   i_trap             force next PC to TRAP_VEC
//   o_pc               registered current PC
//   o_pc_plus_inc      combinational o_pc + INC (wraps modulo 2^WIDTH)
//   o_ras_count        number of valid RAS entries
//   o_ras_underflow    1-cycle pulse: ret taken with an empty RAS
//   o_misaligned       1-cycle pulse: redirect target not a multiple of INC
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter int               INC       = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_0080),
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_redirect_valid,
    input  logic [WIDTH-1:0]             i_redirect_target,
    input  logic                         i_call,
    input  logic                         i_ret,
    input  logic                         i_trap,
    output logic [WIDTH-1:0]             o_pc,
    output logic [WIDTH-1:0]             o_pc_plus_inc,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_underflow,
    output logic                         o_misaligned
);

    localparam int               PW         = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] W_INC      = WIDTH'(INC);
    // Low bits that must be zero in an aligned target; all-zero when INC == 1.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    localparam logic [PW:0]      CNT_FULL   = (PW + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;     // index of the current top entry
    logic [PW:0]      r_cnt;
    logic             r_unf;
    logic             r_mis;

    logic [WIDTH-1:0] w_ppi;
    logic             w_tgt_mis;
    logic             w_mis_evt;
    logic             w_take_redir;
    logic             w_push;
    logic             w_repl;
    logic             w_ret_cyc;
    logic             w_pop;
    logic             w_unf;
    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;

    assign w_ppi        = r_pc + W_INC;
    assign w_tgt_mis    = (i_redirect_target & ALIGN_MASK) != '0;
    assign w_mis_evt    = !i_trap && i_redirect_valid && w_tgt_mis;
    assign w_take_redir = !i_trap && i_redirect_valid && !w_tgt_mis;
    // call+ret in one accepted redirect replaces the top instead of pushing.
    assign w_push       = w_take_redir && i_call && !i_ret;
    assign w_repl       = w_take_redir && i_call && i_ret;
    // ret only acts when nothing of higher priority claims the cycle.
    assign w_ret_cyc    = !i_trap && !i_redirect_valid && !i_stall && i_ret;
    assign w_pop        = w_ret_cyc && (r_cnt != '0);
    assign w_unf        = w_ret_cyc && (r_cnt == '0);
    assign w_top_inc    = r_top + 1'b1;
    assign w_top_dec    = r_top - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
            r_top <= '0;
            r_unf <= 1'b0;
            r_mis <= 1'b0;
        end else begin
            r_unf <= w_unf;
            r_mis <= w_mis_evt;

            if (i_trap || w_mis_evt)   r_pc <= TRAP_VEC;
            else if (w_take_redir)     r_pc <= i_redirect_target;
            else if (i_stall)          r_pc <= r_pc;
            else if (w_pop)            r_pc <= r_ras[r_top];
            else                       r_pc <= w_ppi;

            if (w_push) begin
                // Circular: when full, the pointer advances onto the oldest entry.
                r_top <= w_top_inc;
                if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
            end else if (w_repl) begin
                if (r_cnt == '0) r_cnt <= (PW + 1)'(1);
            end else if (w_pop) begin
                r_top <= w_top_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Stack storage is deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_push)      r_ras[w_top_inc] <= w_ppi;
            else if (w_repl) r_ras[r_top]     <= w_ppi;
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_plus_inc   = w_ppi;
    assign o_ras_count     = r_cnt;
    assign o_ras_underflow = r_unf;
    assign o_misaligned    = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, rv, call, ret, trap;
    logic [31:0] tgt;
    logic [31:0] pc, ppi;
    logic [2:0]  cnt;
    logic        unf, mis;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        unf;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect_valid (rv),
        .i_redirect_target(tgt),
        .i_call           (call),
        .i_ret            (ret),
        .i_trap           (trap),
        .o_pc             (pc),
        .o_pc_plus_inc    (ppi),
        .o_ras_count      (cnt),
        .o_ras_underflow  (unf),
        .o_misaligned     (mis)
    );

    // Drive one cycle of inputs, queue the state expected after the edge,
    // then compare the DUT against the oldest queued expectation.
    task automatic step(input string tag, input logic r, input logic st,
                        input logic v, input logic [31:0] t, input logic c,
                        input logic rt, input logic tr,
                        input logic [31:0] epc, input logic [2:0] ecnt,
                        input logic eunf, input logic emis);
        exp_t e;
        logic [31:0] eppi;
        rst = r; stall = st; rv = v; tgt = t; call = c; ret = rt; trap = tr;
        sb.push_back('{tag, epc, ecnt, eunf, emis});
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            eppi = e.pc + 32'd4;
            checks++;
            assert (pc === e.pc) else begin
                errors++; $error("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc);
            end
            checks++;
            assert (ppi === eppi) else begin
                errors++; $error("FAIL %s pc_plus_inc: got %h expected %h", e.tag, ppi, eppi);
            end
            checks++;
            assert (cnt === e.cnt) else begin
                errors++; $error("FAIL %s ras_count: got %0d expected %0d", e.tag, cnt, e.cnt);
            end
            checks++;
            assert (unf === e.unf) else begin
                errors++; $error("FAIL %s ras_underflow: got %b expected %b", e.tag, unf, e.unf);
            end
            checks++;
            assert (mis === e.mis) else begin
                errors++; $error("FAIL %s misaligned: got %b expected %b", e.tag, mis, e.mis);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = '0; call = 1'b0; ret = 1'b0; trap = 1'b0;

        //    tag           rst st  rv  tgt           c   ret trp  pc            cnt unf mis
        step("reset",       1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0);
        step("run1",        0, 0, 0, 32'h0,        0, 0, 0, 32'h4,        0, 0, 0);
        step("run2",        0, 0, 0, 32'h0,        0, 0, 0, 32'h8,        0, 0, 0);
        step("run3",        0, 0, 0, 32'h0,        0, 0, 0, 32'hC,        0, 0, 0);
        step("run4",        0, 0, 0, 32'h0,        0, 0, 0, 32'h10,       0, 0, 0);
        step("stall1",      0, 1, 0, 32'h0,        0, 0, 0, 32'h10,       0, 0, 0);
        step("stall2",      0, 1, 0, 32'h0,        0, 0, 0, 32'h10,       0, 0, 0);
        step("stall3",      0, 1, 0, 32'h0,        0, 0, 0, 32'h10,       0, 0, 0);
        step("unstall",     0, 0, 0, 32'h0,        0, 0, 0, 32'h14,       0, 0, 0);
        step("redir_stall", 0, 1, 1, 32'h40,       0, 0, 0, 32'h40,       0, 0, 0);

        // call / return
        step("to_20",       0, 0, 1, 32'h20,       0, 0, 0, 32'h20,       0, 0, 0);
        step("call_100",    0, 0, 1, 32'h100,      1, 0, 0, 32'h100,      1, 0, 0);
        step("run_104",     0, 0, 0, 32'h0,        0, 0, 0, 32'h104,      1, 0, 0);
        step("run_108",     0, 0, 0, 32'h0,        0, 0, 0, 32'h108,      1, 0, 0);
        step("ret_24",      0, 0, 0, 32'h0,        0, 1, 0, 32'h24,       0, 0, 0);
        step("ret_unf",     0, 0, 0, 32'h0,        0, 1, 0, 32'h28,       0, 1, 0);
        step("unf_clear",   0, 0, 0, 32'h0,        0, 0, 0, 32'h2C,       0, 0, 0);

        // RAS overflow: five calls into a 4-deep stack
        step("to_0",        0, 0, 1, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0);
        step("call_a",      0, 0, 1, 32'h100,      1, 0, 0, 32'h100,      1, 0, 0);
        step("call_b",      0, 0, 1, 32'h200,      1, 0, 0, 32'h200,      2, 0, 0);
        step("call_c",      0, 0, 1, 32'h300,      1, 0, 0, 32'h300,      3, 0, 0);
        step("call_d",      0, 0, 1, 32'h400,      1, 0, 0, 32'h400,      4, 0, 0);
        step("call_e",      0, 0, 1, 32'h500,      1, 0, 0, 32'h500,      4, 0, 0);
        step("ret_stall",   0, 1, 0, 32'h0,        0, 1, 0, 32'h500,      4, 0, 0);
        step("ret_404",     0, 0, 0, 32'h0,        0, 1, 0, 32'h404,      3, 0, 0);
        step("ret_304",     0, 0, 0, 32'h0,        0, 1, 0, 32'h304,      2, 0, 0);
        step("ret_204",     0, 0, 0, 32'h0,        0, 1, 0, 32'h204,      1, 0, 0);
        step("ret_104",     0, 0, 0, 32'h0,        0, 1, 0, 32'h104,      0, 0, 0);
        step("ret_lost",    0, 0, 0, 32'h0,        0, 1, 0, 32'h108,      0, 1, 0);

        // misaligned / trap leave the RAS alone
        step("call_600",    0, 0, 1, 32'h600,      1, 0, 0, 32'h600,      1, 0, 0);
        step("misalign",    0, 0, 1, 32'h102,      1, 0, 0, 32'h80,       1, 0, 1);
        step("mis_clear",   0, 0, 0, 32'h0,        0, 0, 0, 32'h84,       1, 0, 0);
        step("trap_redir",  0, 0, 1, 32'h200,      1, 0, 1, 32'h80,       1, 0, 0);
        step("ret_10c",     0, 0, 0, 32'h0,        0, 1, 0, 32'h10C,      0, 0, 0);
        step("redir_ret",   0, 0, 1, 32'h180,      0, 1, 0, 32'h180,      0, 0, 0);

        // call+ret in one redirect on an empty stack: count becomes 1
        step("call_ret",    0, 0, 1, 32'h700,      1, 1, 0, 32'h700,      1, 0, 0);
        step("ret_184",     0, 0, 0, 32'h0,        0, 1, 0, 32'h184,      0, 0, 0);
        step("call_norv",   0, 0, 0, 32'h0,        1, 0, 0, 32'h188,      0, 0, 0);

        // wrap-around and reset overriding everything
        step("to_top",      0, 0, 1, 32'hFFFF_FFFC,0, 0, 0, 32'hFFFF_FFFC,0, 0, 0);
        step("wrap",        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0);
        step("call_800",    0, 0, 1, 32'h800,      1, 0, 0, 32'h800,      1, 0, 0);
        step("rst_call",    1, 0, 1, 32'h900,      1, 0, 0, 32'h0,        0, 0, 0);
        step("rst_mis",     1, 0, 1, 32'h902,      0, 1, 1, 32'h0,        0, 0, 0);
        step("post_rst",    0, 0, 0, 32'h0,        0, 0, 0, 32'h4,        0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
